// File: rtl/neuron_mac_seq_pkg.sv
// Shared MLP datapath definitions: FSM states, select width, lane-sum sizing
// and the default lane geometry used by the mux instances and the MAC stage.
package mlp_pkg;

   localparam int SEL_W     = 3;
   localparam int W_DEF     = 8;
   localparam int LANES_DEF = 8;
   localparam int N_DEF     = W_DEF * LANES_DEF;
   localparam int ACC_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Full-precision width of a sum of LANES signed WxW products.
   function automatic int lane_sum_w(input int w, input int lanes);
      return 2 * w + $clog2(lanes);
   endfunction

endpackage

// File: rtl/neuron_mac_seq_lane_dot.sv
// lane_dot: combinational signed dot product of two packed words, returning
// the full-precision lane sum sign-extended to OUT_W.
module lane_dot
   import mlp_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int LANES = LANES_DEF,
   parameter int OUT_W = ACC_W_DEF
) (
   input  logic [W*LANES-1:0]       a,
   input  logic [W*LANES-1:0]       b,
   output logic signed [OUT_W-1:0]  dot
);

   localparam int SW = lane_sum_w(W, LANES);

   logic signed [SW-1:0]  sum;
   logic signed [W-1:0]   al;
   logic signed [W-1:0]   bl;
   logic signed [2*W-1:0] prod;

   always_comb begin
      sum  = '0;
      al   = '0;
      bl   = '0;
      prod = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         al   = a[i*W +: W];
         bl   = b[i*W +: W];
         prod = (2*W)'(al) * (2*W)'(bl);
         sum  = sum + SW'(prod);
      end
   end

   assign dot = OUT_W'(sum);

endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: walks the shared mux select, accumulates lane dot products
// onto a bias and presents one result per job. Define NEURON_RELU_EN for ReLU output.
module neuron_mac_seq
   import mlp_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int W       = W_DEF,
   parameter int LANES   = LANES_DEF,
   parameter int NUM_SEL = 8,
   parameter int ACC_W   = ACC_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [ACC_W-1:0] bias,
   output logic [SEL_W-1:0]        sel,
   input  logic [N-1:0]            act_in,
   input  logic [N-1:0]            wgt_in,
   output logic                    busy,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_data
);

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SEL - 1);

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] psum_reg;
   logic                    psum_valid;
   logic signed [ACC_W-1:0] dot;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] result;

   lane_dot #(
      .W     (W),
      .LANES (LANES),
      .OUT_W (ACC_W)
   ) u_lane_dot (
      .a   (act_in),
      .b   (wgt_in),
      .dot (dot)
   );

   assign acc_sum = acc + psum_reg;

`ifdef NEURON_RELU_EN
   assign result = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
   assign result = acc_sum;
`endif

   // Products are registered one cycle behind sel, so the final term lands in DRAIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sel        <= '0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         acc        <= '0;
         psum_reg   <= '0;
         psum_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc        <= bias;
                  sel        <= '0;
                  busy       <= 1'b1;
                  psum_valid <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               psum_reg   <= dot;
               psum_valid <= 1'b1;
               if (psum_valid)
                  acc <= acc_sum;
               if (sel == SEL_LAST) begin
                  sel   <= '0;
                  state <= DRAIN;
               end else begin
                  sel <= sel + SEL_W'(1);
               end
            end
            DRAIN: begin
               acc        <= acc_sum;
               out_data   <= result;
               out_valid  <= 1'b1;
               psum_valid <= 1'b0;
               state      <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: table-driven jobs, scoreboard on the
// output handshake, and hand-written backpressure / reset / back-to-back sequences.
module tb_neuron_mac_seq;

   localparam int N       = 64;
   localparam int W       = 8;
   localparam int LANES   = 8;
   localparam int NUM_SEL = 8;
   localparam int ACC_W   = 32;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    start = 1'b0;
   logic signed [ACC_W-1:0] bias = '0;
   logic [2:0]              sel;
   logic [N-1:0]            act_in;
   logic [N-1:0]            wgt_in;
   logic                    busy;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic signed [ACC_W-1:0] out_data;

   logic [N-1:0] act_mem [8];
   logic [N-1:0] wgt_mem [8];

   int errors = 0;
   int checks = 0;

   logic signed [ACC_W-1:0] sb_q [$];
   logic                    hold_v = 1'b0;
   logic signed [ACC_W-1:0] hold_d = '0;
   int                      cyc = 0;
   int                      hs_cyc [$];

   always #5 clk = ~clk;

   assign act_in = act_mem[sel];
   assign wgt_in = wgt_mem[sel];

   neuron_mac_seq #(
      .N       (N),
      .W       (W),
      .LANES   (LANES),
      .NUM_SEL (NUM_SEL),
      .ACC_W   (ACC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bias      (bias),
      .sel       (sel),
      .act_in    (act_in),
      .wgt_in    (wgt_in),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic signed [ACC_W-1:0] model(input logic signed [ACC_W-1:0] b);
      logic signed [ACC_W-1:0] s;
      logic signed [W-1:0]     a8;
      logic signed [W-1:0]     w8;
      s = b;
      for (int k = 0; k < NUM_SEL; k++)
         for (int l = 0; l < LANES; l++) begin
            a8 = act_mem[k][l*W +: W];
            w8 = wgt_mem[k][l*W +: W];
            s  = s + int'(a8) * int'(w8);
         end
`ifdef NEURON_RELU_EN
      if (s < 0) s = '0;
`endif
      return s;
   endfunction

   // Signals are stable at the falling edge; what is seen here is what the next rising edge samples.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         sb_q.delete();
         hold_v = 1'b0;
      end else begin
         if (start && !busy)
            sb_q.push_back(model(bias));
         if (out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (sb_q.size() == 0)
               check("sb_unexpected_output", 1, 0);
            else
               check("sb_out_data", out_data, sb_q.pop_front());
         end
         if (out_valid && !out_ready) begin
            if (hold_v)
               check("hold_stable", out_data, hold_d);
            hold_v = 1'b1;
            hold_d = out_data;
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   task automatic drive_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic fill_uniform(input logic [7:0] a, input logic [7:0] w);
      for (int k = 0; k < 8; k++) begin
         act_mem[k] = {8{a}};
         wgt_mem[k] = {8{w}};
      end
   endtask

   // Launch one job with out_ready high and check sel stepping, latency, result and release.
   task automatic run_job(input string name, input logic signed [ACC_W-1:0] exp);
      int  c;
      bit  sel_ok;
      drive_edge();
      start = 1'b1;
      drive_edge();
      start  = 1'b0;
      c      = 0;
      sel_ok = 1'b1;
      while (c < 40) begin
         @(negedge clk);
         c++;
         if (c <= NUM_SEL && sel != 3'(c - 1)) sel_ok = 1'b0;
         if (c == NUM_SEL + 1 && sel != 3'd0) sel_ok = 1'b0;
         if (out_valid) break;
      end
      check({name, "_sel_seq"}, sel_ok, 1);
      check({name, "_latency"}, c, NUM_SEL + 2);
      check({name, "_out_data"}, out_data, exp);
      @(negedge clk);
      check({name, "_released"}, {out_valid, busy}, 2'b00);
   endtask

   typedef struct {
      string                   name;
      logic signed [ACC_W-1:0] b;
      logic [7:0]              a;
      logic [7:0]              w;
      logic signed [ACC_W-1:0] exp;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int  c;
      bit  ok;
      logic signed [ACC_W-1:0] e;

      tbl[0] = '{"basic",    32'sd5,            8'd1,    8'd2,    32'sd133};
      tbl[1] = '{"negneg",   32'sd0,            8'h80,   8'h80,   32'sd1048576};
`ifdef NEURON_RELU_EN
      tbl[2] = '{"negpos",   32'sd0,            8'h80,   8'h7f,   32'sd0};
      tbl[3] = '{"mixed",    -32'sd100,         8'd3,    8'hf9,   32'sd0};
      tbl[4] = '{"wrap",     32'sh7ffffff0,     8'd1,    8'd1,    32'sd0};
`else
      tbl[2] = '{"negpos",   32'sd0,            8'h80,   8'h7f,   -32'sd1040384};
      tbl[3] = '{"mixed",    -32'sd100,         8'd3,    8'hf9,   -32'sd1444};
      tbl[4] = '{"wrap",     32'sh7ffffff0,     8'd1,    8'd1,    32'sh80000030};
`endif
      fill_uniform(8'd0, 8'd0);

      // Reset with start asserted: nothing may launch.
      rst   = 1'b1;
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_sel", sel, 0);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      drive_edge();
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      check("idle_after_rst", {busy, out_valid}, 2'b00);

      for (int i = 0; i < 5; i++) begin
         fill_uniform(tbl[i].a, tbl[i].w);
         bias = tbl[i].b;
         run_job(tbl[i].name, tbl[i].exp);
      end

      for (int j = 0; j < 3; j++) begin
         for (int k = 0; k < 8; k++) begin
            act_mem[k] = {$urandom, $urandom};
            wgt_mem[k] = {$urandom, $urandom};
         end
         bias = $urandom;
         run_job("random", model(bias));
      end

      // Backpressure: hold result 5 cycles, pulse start during HOLD.
      fill_uniform(8'd2, 8'd3);
      bias      = 32'sd7;
      e         = model(bias);
      out_ready = 1'b0;
      drive_edge();
      start = 1'b1;
      drive_edge();
      start = 1'b0;
      c = 0;
      while (!out_valid && c < 40) begin
         @(negedge clk);
         c++;
      end
      check("bp_valid_seen", out_valid, 1);
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (!(out_valid && busy && out_data == e)) ok = 1'b0;
         drive_edge();
         start = (k == 1);
         @(negedge clk);
      end
      check("bp_hold_state", ok, 1);
      drive_edge();
      start     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_handshake_data", out_data, e);
      @(negedge clk);
      check("bp_idle_after", {out_valid, busy}, 2'b00);
      repeat (3) @(negedge clk);
      check("bp_no_relaunch", busy, 0);

      // Reset mid-job at sel=4, then a fresh job.
      fill_uniform(8'd9, 8'd9);
      bias = 32'sd1000;
      drive_edge();
      start = 1'b1;
      drive_edge();
      start = 1'b0;
      c = 0;
      while (sel != 3'd4 && c < 20) begin
         @(negedge clk);
         c++;
      end
      check("abort_reached_sel4", sel, 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_state", {busy, out_valid, sel}, 5'b0);
      ok = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) ok = 1'b0;
      end
      check("abort_no_output", ok, 1);
      fill_uniform(8'd5, 8'd0);
      bias = -32'sd3;
`ifdef NEURON_RELU_EN
      run_job("after_abort", 32'sd0);
`else
      run_job("after_abort", -32'sd3);
`endif

      // Back-to-back jobs with start held high.
      fill_uniform(8'hff, 8'd4);
      bias = 32'sd11;
      hs_cyc.delete();
      drive_edge();
      start = 1'b1;
      c = 0;
      while (hs_cyc.size() < 3 && c < 100) begin
         @(negedge clk);
         c++;
      end
      drive_edge();
      start = 1'b0;
      check("b2b_count", hs_cyc.size(), 3);
      if (hs_cyc.size() >= 3) begin
         check("b2b_period1", hs_cyc[1] - hs_cyc[0], NUM_SEL + 3);
         check("b2b_period2", hs_cyc[2] - hs_cyc[1], NUM_SEL + 3);
      end
      repeat (15) @(negedge clk);
      check("b2b_idle", {busy, out_valid}, 2'b00);
      check("sb_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Sequencer and multiply-accumulate stage that sits directly downstream of the 8-to-1 input/weight multiplexers in the MLP datapath.
- Drives the shared 3-bit select, consumes the selected packed activation and weight words, and accumulates lane-wise signed products onto a bias.
- Presents one neuron pre-activation (or ReLU output) per job on a valid/ready output.

Parameters:
- N, 64, packed mux word width; must equal LANES*W.
- W, 8, signed lane width of activations and weights.
- LANES, 8, lanes per packed word.
- NUM_SEL, 8, number of mux inputs walked per job; range 1..8.
- ACC_W, 32, signed accumulator/output width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  job request; sampled only in IDLE.
- bias  input  ACC_W  signed initial accumulator value; sampled on accepted start.
- sel  output  3  select to both external muxes.
- act_in  input  N  packed activations from the activation mux (combinational on sel).
- wgt_in  input  N  packed weights from the weight mux (combinational on sel).
- busy  output  1  high from accepted start until output handshake completes.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- out_data  output  ACC_W  signed result.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: sel=0, busy=0, out_valid=0, out_data=0, accumulator=0, pipeline valid=0, state=IDLE.
- Reset mid-job returns the block to IDLE and discards the partial sum; no output is produced.
- FSM states: IDLE, RUN, DRAIN, HOLD.
- IDLE: on start=1 at an edge, acc<=bias, sel<=0, busy<=1, go to RUN.
- RUN: each cycle, psum_reg<=sum over lanes of signed(act_in[i])*signed(wgt_in[i]), sign-extended to ACC_W, and psum_valid<=1. If psum_valid, acc<=acc+psum_reg. While sel<NUM_SEL-1, sel increments. At sel=NUM_SEL-1, sel<=0 and go to DRAIN.
- DRAIN: acc<=acc+psum_reg (last term), psum_valid<=0, go to HOLD.
- HOLD: out_valid=1 and out_data=final value, both held stable until out_ready=1. On that handshake edge: out_valid<=0, busy<=0, go to IDLE.
- out_ready is ignored whenever out_valid=0.
- Latency: out_valid rises NUM_SEL+2 cycles after the start-accept edge (10 at default). Minimum job period is NUM_SEL+3 cycles with out_ready tied high.
- start while busy is ignored and not queued.
- start on the same edge as the output handshake is ignored; it is accepted on the next IDLE cycle.
- Arithmetic: products are 2W bits; the lane sum is 2W+clog2(LANES) bits. The accumulator wraps modulo 2^ACC_W with no saturation.
- sel holds 0 outside RUN.

Optional Feature:
- Macro: NEURON_RELU_EN.
- Defined: out_data = (acc<0) ? 0 : acc, computed when entering HOLD.
- Undefined: out_data = acc, the raw signed value.
- Latency and handshake are identical in both builds.

Decomposition:
- Package mlp_pkg holds:
  - the FSM state enum (IDLE/RUN/DRAIN/HOLD);
  - localparam SEL_W=3;
  - the lane-sum width function;
  - default W/LANES/ACC_W constants shared with the mux instances.
- One sub-module, lane_dot: combinational signed dot product of two packed N-bit words returning the sign-extended lane sum; instantiated once.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst high 3 cycles.
  - Response: all outputs 0, sel=0, busy=0; start during rst is ignored.
- Basic job:
  - Stimulus: all act lanes=1, all wgt lanes=2 for every sel, bias=5, out_ready=1.
  - Response: sel steps 0..7 over 8 cycles; out_valid rises on cycle 10 with out_data=5+8*8*2=133, held exactly 1 cycle.
- Signed/extreme values:
  - Stimulus: act lanes=-128, wgt lanes=-128, bias=0.
  - Response: out_data=8*8*16384=1048576.
  - Stimulus: act=-128, wgt=127.
  - Response: out_data=-1040384 (raw build); 0 with NEURON_RELU_EN.
- Backpressure and ignored start:
  - Stimulus: out_ready=0 for 5 cycles after out_valid; pulse start during HOLD.
  - Response: out_data stable, busy=1, the start pulse does not launch a new job; handshake on the 6th cycle, then IDLE.
- Reset mid-job:
  - Stimulus: assert rst when sel=4, then run a fresh job with bias=-3 and zero weights.
  - Response: no out_valid from the aborted job; the new job yields out_data=-3 (raw) or 0 (ReLU).
- Back-to-back jobs:
  - Stimulus: start held high, out_ready=1, NUM_SEL=8.
  - Response: jobs complete every 11 cycles with no lost or duplicated results.
